// File: rtl/conv_apb_pkg.sv
// Shared types and constants for the convolution-core APB initiator.
package conv_apb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  // Convolution slave register byte offsets
  localparam logic [31:0] REG_COMMAND     = 32'h0000_0000;
  localparam logic [31:0] REG_INPUT_LEN   = 32'h0000_0004;
  localparam logic [31:0] REG_OUTPUT_LEN  = 32'h0000_0008;
  localparam logic [31:0] REG_WIDTH       = 32'h0000_000C;
  localparam logic [31:0] REG_RD_DONE     = 32'h0000_0010;
  localparam logic [31:0] REG_CONV_DONE   = 32'h0000_0014;
  localparam logic [31:0] REG_CLK_COUNTER = 32'h0000_0018;

endpackage

// File: rtl/apb_req_fifo.sv
// Request FIFO holding {write, addr, wdata}; push/pop are ignored when full/empty.
module apb_req_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/apb_conv_master.sv
// APB3 initiator: queues register requests, runs them one at a time on APB,
// and returns one response per request, with a watchdog on stalled ACCESS.
//
// state  | meaning
// IDLE   | waiting for a queued request
// SETUP  | PSEL=1, PENABLE=0, one cycle
// ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or watchdog
// RESP   | response held on rsp_* until rsp_ready
module apb_conv_master
  import conv_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int EW    = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  apb_state_t state_q, state_d;

  logic                       ready_en;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [EW-1:0]              fifo_wdata;
  logic [EW-1:0]              fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  timeout_q;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_expire;
  logic                  in_xfer;

  // Holds req_ready low through reset and releases it on the first clock after
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  assign req_ready  = ready_en && !fifo_full;
  assign fifo_push  = req_valid && req_ready;
  assign fifo_wdata = {req_write, req_addr, req_wdata};

  apb_req_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign wd_expire = WD_EN && !PREADY && (wd_cnt == WD_LAST);

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and FIFO pop decode
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = SETUP;
          fifo_pop = 1'b1;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || wd_expire) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer latch, watchdog count and response capture
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      wd_cnt    <= '0;
    end else if (fifo_pop) begin
      pwrite_q  <= fifo_rdata[EW-1];
      paddr_q   <= fifo_rdata[DATA_WIDTH +: ADDR_WIDTH];
      pwdata_q  <= fifo_rdata[EW-1] ? fifo_rdata[DATA_WIDTH-1:0] : '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      wd_cnt    <= '0;
    end else if (state_q == ACCESS) begin
      if (PREADY) begin
        rdata_q <= pwrite_q ? '0 : PRDATA;
        err_q   <= PSLVERR;
      end else if (wd_expire) begin
        rdata_q   <= '0;
        err_q     <= 1'b1;
        timeout_q <= 1'b1;
      end else if (wd_cnt != '1) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end

  assign in_xfer     = (state_q == SETUP) || (state_q == ACCESS);
  assign PSEL        = in_xfer;
  assign PENABLE     = (state_q == ACCESS);
  assign PWRITE      = in_xfer && pwrite_q;
  assign PADDR       = in_xfer ? paddr_q  : '0;
  assign PWDATA      = in_xfer ? pwdata_q : '0;

  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_valid ? rdata_q : '0;
  assign rsp_err     = rsp_valid && err_q;
  assign rsp_timeout = rsp_valid && timeout_q;

  assign busy = (fifo_count != '0) || (state_q != IDLE) || rsp_valid;

endmodule
